// File: rtl/core_pkg.sv
// Shared definitions for the core: FSM states, branch condition codes,
// default widths and the branch-target table used by branch_lut.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] COND_ALW = 2'b00;
    localparam logic [1:0] COND_Z   = 2'b01;
    localparam logic [1:0] COND_LT  = 2'b10;
    localparam logic [1:0] COND_NZ  = 2'b11;

    localparam int PC_W_DEF    = 10;
    localparam int IDX_W_DEF   = 5;
    localparam int TABLE_DEPTH = 2 ** IDX_W_DEF;
    localparam int TABLE_W     = 16;

    typedef logic [TABLE_DEPTH-1:0][TABLE_W-1:0] table_t;

    // Default table places target k at 32*k; the assembler may regenerate this.
    function automatic table_t build_table();
        table_t t;
        for (int k = 0; k < TABLE_DEPTH; k++) begin
            t[k] = TABLE_W'(32 * k);
        end
        return t;
    endfunction

    localparam table_t BRANCH_TABLE = build_table();

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target ROM: maps a target index to an absolute PC
// using the shared package table.
module branch_lut
    import core_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic [IDX_W-1:0] idx,
    output logic [PC_W-1:0]  target
);

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        target = '0;
        for (int k = 0; k < TABLE_DEPTH; k++) begin
            if (k < 2 ** IDX_W && idx == IDX_W'(k)) begin
                target = PC_W'(BRANCH_TABLE[k]);
            end
        end
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter, ALU flag register and Start/Done program FSM; conditional
// branches resolve on the registered flags through the branch-target LUT.
module pc_branch_ctrl
    import core_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              IDX_W    = IDX_W_DEF,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Zero_in,
    input  logic             LT_in,
    input  logic             FlagWe,
    input  logic             Branch,
    input  logic [1:0]       Cond,
    input  logic [IDX_W-1:0] TargetIdx,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             Zero_q,
    output logic             LT_q,
    output logic             Running,
    output logic             Done
);

    state_t          state;
    logic [PC_W-1:0] lut_target;
    logic            cond_true;
    logic [PC_W-1:0] next_pc;

    branch_lut #(
        .IDX_W (IDX_W),
        .PC_W  (PC_W)
    ) u_lut (
        .idx    (TargetIdx),
        .target (lut_target)
    );

    // Conditions look only at the latched flags, so a same-cycle FlagWe sees old values.
    always_comb begin
        case (Cond)
            COND_ALW: cond_true = 1'b1;
            COND_Z:   cond_true = Zero_q;
            COND_LT:  cond_true = LT_q;
            default:  cond_true = !Zero_q;
        endcase
    end

    assign next_pc = (Branch && cond_true) ? lut_target : PC + PC_W'(1);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            PC      <= START_PC;
            Zero_q  <= 1'b0;
            LT_q    <= 1'b0;
            Running <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= RUN;
                        PC      <= START_PC;
                        Running <= 1'b1;
                    end
                end
                RUN: begin
                    if (FlagWe) begin
                        Zero_q <= Zero_in;
                        LT_q   <= LT_in;
                    end
                    if (Halt) begin
                        state   <= DONE;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else begin
                        PC <= next_pc;
                    end
                end
                DONE: begin
                    if (Start) begin
                        state   <= RUN;
                        PC      <= START_PC;
                        Zero_q  <= 1'b0;
                        LT_q    <= 1'b0;
                        Running <= 1'b1;
                        Done    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
